// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared widths, memory size and FSM encoding for the load/store path
package load_store_unit_pkg;

  localparam int LSU_DATA_W    = 16;
  localparam int LSU_ADDR_W    = 16;
  localparam int LSU_MEM_WORDS = 8;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_req_fifo.sv
// rtl/load_store_unit_req_fifo.sv - request queue; count is one bit wider than the pointers to tell full from empty
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - queued CPU load/store requests, one memory access per request, in-order responses
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W     = LSU_DATA_W,
  parameter int ADDR_W     = LSU_ADDR_W,
  parameter int MEM_WORDS  = LSU_MEM_WORDS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int REQ_W = 1 + ADDR_W + DATA_W;

  lsu_state_e        state;
  lsu_state_e        state_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [REQ_W-1:0]  fifo_dout;
  logic              iss_we;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_wdata;
  logic              iss_in_range;

  assign req_ready = !fifo_full;

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .din   ({req_we, req_addr, req_wdata}),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // Head is popped on the edge that enters ACCESS, from IDLE or straight out of a completed RESP
  assign fifo_pop = !fifo_empty &&
                    ((state == LSU_IDLE) || ((state == LSU_RESP) && resp_ready));

  assign iss_in_range = ({1'b0, iss_addr} < (ADDR_W+1)'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE:   if (!fifo_empty) state_next = LSU_ACCESS;
      LSU_ACCESS: state_next = LSU_RESP;
      LSU_RESP:   if (resp_ready) state_next = fifo_empty ? LSU_IDLE : LSU_ACCESS;
      default:    state_next = LSU_IDLE;
    endcase
  end

  always_comb begin
    resp_valid      = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    case (state)
      LSU_ACCESS: begin
        mem_access_addr = iss_addr;
        if (iss_in_range) begin
          mem_write_en   = iss_we;
          mem_read       = !iss_we;
          mem_write_data = iss_we ? iss_wdata : '0;
        end
      end
      LSU_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_we     <= 1'b0;
      iss_addr   <= '0;
      iss_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (fifo_pop) {iss_we, iss_addr, iss_wdata} <= fifo_dout;
      // Response fields settle at the end of ACCESS and hold through RESP
      if (state == LSU_ACCESS) begin
        resp_rdata <= mem_read ? mem_read_data : '0;
        resp_err   <= !iss_in_range;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed bench against a queue/array reference model
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] mem_access_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          mem_write_en, mem_read;

  always #5 clk = ~clk;

  load_store_unit #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(MW), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // Data memory: combinational read, write on the edge ending the strobe cycle
  logic [DW-1:0] tb_mem [MW];
  assign mem_read_data = (mem_read && mem_access_addr < MW) ? tb_mem[mem_access_addr[2:0]] : 16'hBEEF;
  always @(posedge clk)
    if (mem_write_en && mem_access_addr < MW) tb_mem[mem_access_addr[2:0]] <= mem_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int both_strobe_cnt = 0, oor_strobe_cnt = 0, resp_busy_cnt = 0, access_cnt = 0;
  always @(negedge clk) begin
    if (mem_read && mem_write_en) both_strobe_cnt <= both_strobe_cnt + 1;
    if ((mem_read || mem_write_en) && mem_access_addr >= MW) oor_strobe_cnt <= oor_strobe_cnt + 1;
    if (resp_valid && (mem_read || mem_write_en || mem_access_addr != 0 || mem_write_data != 0))
      resp_busy_cnt <= resp_busy_cnt + 1;
    if (mem_read || mem_write_en) access_cnt <= access_cnt + 1;
  end

  logic [DW-1:0] ref_mem [MW];
  logic [DW:0]   exp_q [$];
  int            acc_cyc_q [$];
  int n_vec = 0, n_bad = 0;
  int accept_cnt = 0, resp_cnt = 0, last_lat = -1;
  logic prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_accept();
    if (req_addr >= MW) exp_q.push_back({1'b1, 16'h0});
    else if (req_we) begin
      ref_mem[req_addr[2:0]] = req_wdata;
      exp_q.push_back({1'b0, 16'h0});
    end else exp_q.push_back({1'b0, ref_mem[req_addr[2:0]]});
    acc_cyc_q.push_back(cyc + 1);
  endtask

  // One clock: bookkeeping on settled signals after a negedge, then advance to the next negedge
  task automatic step();
    logic [DW:0] e;
    #1;
    if (resp_valid && !prev_valid && acc_cyc_q.size() > 0) last_lat = cyc - acc_cyc_q[0];
    if (req_valid && req_ready) begin
      model_accept();
      accept_cnt++;
    end
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_resp", 1, 0);
      else begin
        e = exp_q.pop_front();
        void'(acc_cyc_q.pop_front());
        check_eq("resp_rdata", resp_rdata, e[DW-1:0]);
        check_eq("resp_err", resp_err, e[DW]);
        resp_cnt++;
      end
    end
    prev_valid = resp_valid;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves req_valid high so consecutive calls are back-to-back
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int a0;
    a0 = accept_cnt;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 40 && accept_cnt == a0; i++) step();
    if (accept_cnt == a0) check_eq("accept_timeout", 1, 0);
  endtask

  task automatic wait_resp();
    int r0;
    r0 = resp_cnt;
    for (int i = 0; i < 40 && resp_cnt == r0; i++) step();
    if (resp_cnt == r0) check_eq("resp_timeout", 1, 0);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int a0, c0, ac0, seen;
    logic [DW-1:0] hold_rdata, ref_old;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    @(negedge clk);
    check_eq("reset_outputs",
             {resp_valid, resp_rdata, resp_err, mem_read, mem_write_en, mem_access_addr, mem_write_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("req_ready_after_reset", req_ready, 1);

    resp_ready = 1'b1;
    do_req(1'b1, 16'd3, 16'h00A5); req_valid = 1'b0;
    last_lat = -1; wait_resp();
    check_eq("store_latency", last_lat, 2);
    do_req(1'b0, 16'd3, 16'h0); req_valid = 1'b0;
    last_lat = -1; wait_resp();
    check_eq("load_latency", last_lat, 2);

    c0 = cyc;
    for (int i = 0; i < MW; i++) do_req(1'b1, AW'(i), DW'(i + 1));
    for (int i = MW - 1; i >= 0; i--) do_req(1'b0, AW'(i), 16'h0);
    drain();
    check_eq("b2b_16_cycles_ok", (cyc - c0) <= 40, 1);

    resp_ready = 1'b0;
    a0 = accept_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd1;
    for (int i = 0; i < 8; i++) step();
    check_eq("accepts_while_stalled", accept_cnt - a0, 3);
    check_eq("req_ready_when_full", req_ready, 0);
    resp_ready = 1'b1;
    for (int i = 0; i < 8 && accept_cnt - a0 < 4; i++) step();
    req_valid = 1'b0;
    check_eq("fourth_accept", accept_cnt - a0, 4);
    drain();

    do_req(1'b0, 16'd8, 16'h0); req_valid = 1'b0; wait_resp();
    do_req(1'b1, 16'hFFFF, 16'h1234); req_valid = 1'b0; wait_resp();
    check_eq("oor_no_strobe", oor_strobe_cnt, 0);

    resp_ready = 1'b0;
    do_req(1'b0, 16'd5, 16'h0); req_valid = 1'b0;
    for (int i = 0; i < 10 && !resp_valid; i++) step();
    hold_rdata = resp_rdata;
    check_eq("stall_rdata", hold_rdata, 16'd6);
    ac0 = access_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_valid", resp_valid, 1);
      check_eq("stall_rdata_hold", resp_rdata, hold_rdata);
    end
    check_eq("stall_no_reaccess", access_cnt, ac0);
    resp_ready = 1'b1; wait_resp();

    ref_old = ref_mem[2];
    do_req(1'b1, 16'd2, 16'h7777); req_valid = 1'b0;
    for (int i = 0; i < 10 && !mem_write_en; i++) step();
    check_eq("reached_access", mem_write_en, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_outputs",
             {resp_valid, resp_rdata, resp_err, mem_read, mem_write_en, mem_access_addr, mem_write_data}, 0);
    exp_q.delete(); acc_cyc_q.delete(); prev_valid = 1'b0;
    ref_mem[2] = ref_old;
    @(posedge clk); @(negedge clk);
    check_eq("abort_no_write", tb_mem[2], ref_old);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      step();
    end
    check_eq("abort_no_resp", seen, 0);
    check_eq("abort_fifo_empty", req_ready, 1);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      req_valid  = 1'($urandom_range(0, 1));
      resp_ready = ($urandom_range(0, 3) != 0);
      req_we     = 1'($urandom_range(0, 1));
      req_addr   = (r == 9) ? (AW'($urandom) | 16'h0008) : AW'(r);
      req_wdata  = DW'($urandom);
      step();
    end
    drain();
    check_eq("never_both_strobes", both_strobe_cnt, 0);
    check_eq("oor_no_strobe_random", oor_strobe_cnt, 0);
    check_eq("mem_idle_in_resp", resp_busy_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_W, default 16: data word width.
REQ-002 Parameter ADDR_W, default 16: request address width.
REQ-003 Parameter MEM_WORDS, default 8: number of implemented data-memory words; addresses at or above this are out of range.
REQ-004 Parameter FIFO_DEPTH, default 2: request-queue depth, power of two.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  in  1  CPU request present.
REQ-008 req_ready  out  1  queue can accept a request.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  ADDR_W  word address.
REQ-011 req_wdata  in  DATA_W  store data.
REQ-012 resp_valid  out  1  response present.
REQ-013 resp_ready  in  1  CPU accepts response.
REQ-014 resp_rdata  out  DATA_W  load data; 0 for stores and errors.
REQ-015 resp_err  out  1  request address out of range.
REQ-016 mem_access_addr  out  ADDR_W  address to data memory.
REQ-017 mem_write_data  out  DATA_W  store data to data memory.
REQ-018 mem_write_en  out  1  write strobe; memory writes on the clk edge that ends the strobe cycle.
REQ-019 mem_read  out  1  read enable; data-memory read is combinational.
REQ-020 mem_read_data  in  DATA_W  read data from data memory.

Function
REQ-021 Request accepted on any edge where req_valid && req_ready; {we, addr, wdata} pushed into the FIFO.
REQ-022 req_ready = FIFO not full; a same-cycle pop does not raise req_ready (no push-when-full bypass).
REQ-023 Requests are serviced strictly in acceptance order; each yields exactly one response.
REQ-024 FSM states IDLE, ACCESS, RESP; IDLE -> ACCESS when FIFO non-empty (head popped on that edge into an issue register).
REQ-025 ACCESS lasts exactly one cycle: drive mem_access_addr = issue addr; load: mem_read=1, mem_read_data captured into resp_rdata at the ending edge; store: mem_write_en=1, mem_write_data = issue wdata; ACCESS -> RESP.
REQ-026 Out-of-range request (addr >= MEM_WORDS): no mem_read/mem_write_en strobe in ACCESS; response has resp_err=1, resp_rdata=0.
REQ-027 RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_valid && resp_ready.
REQ-028 On response handshake: -> ACCESS (popping the next head) if FIFO non-empty, else -> IDLE.
REQ-029 Latency: request accepted at edge N into an empty unit in IDLE -> resp_valid high from edge N+2; back-to-back throughput one request per 2 cycles with resp_ready held high.
REQ-030 mem_read and mem_write_en are never both 1; both are 0 outside ACCESS.
REQ-031 mem_access_addr and mem_write_data are 0 outside ACCESS.
REQ-032 FIFO read/write pointers wrap modulo FIFO_DEPTH; a count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

Reset
REQ-033 rst_n low asynchronously forces state IDLE, FIFO empty, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write_en=0, mem_access_addr=0, mem_write_data=0; req_ready=1 one cycle after release.
REQ-034 Reset during ACCESS aborts the access; any pending or unreturned request is discarded and no response is produced.

Structure
REQ-035 DATA_W, ADDR_W, MEM_WORDS defaults and the FSM state encoding belong in the shared parameter/include file used by the memory and the CPU.
REQ-036 The request queue is a sub-module, req_fifo, parameterised by width and depth; FSM and datapath live in load_store_unit.

Verification
REQ-037 Store addr 3, data 16'h00A5, then load addr 3 -> store response err=0 rdata=0; load response rdata=16'h00A5, err=0, 2-cycle latency each.
REQ-038 Push 3 loads back-to-back with resp_ready=0 -> req_ready drops after 2 accepted (FIFO) + 1 in issue; no 4th accept until a response handshakes.
REQ-039 Load addr 8 and store addr 16'hFFFF -> resp_err=1, resp_rdata=0, mem_read and mem_write_en never asserted.
REQ-040 Stores to addr 0..7 of values 1..8, then loads 7..0 -> responses 8..1 in order.
REQ-041 Hold resp_ready=0 for 5 cycles on a load response -> resp_valid, resp_rdata stable; memory not re-accessed.
REQ-042 Assert rst_n=0 mid-ACCESS of a store -> all outputs 0 immediately, no response after release, FIFO empty.
